uart_tx_scheduler: RTL and testbench

Shares one UART transmit line between NUM_REQ byte sources, for example the RX echo path and a status/message generator. Arbitrates pending requests round-robin and accepts one byte per frame through a valid/ready handshake. Sequences the 8N1 frame (start, 8 data bits LSB first, stop) at a programmable bit period. Drives the board TX pin directly.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants and the frame sequencer state type.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int   UART_DATA_W     = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping around to index 0.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   winner
);

  int idx;

  // Scan from the farthest offset down so the nearest valid entry wins last.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one 8N1 UART transmitter between NUM_REQ byte sources,
// with a registered TX line and a programmable bit period.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0]                req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                          busy,
  output logic                                          UART_TX
);

  localparam int IDX_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(UART_DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_W - 1);

  uart_state_t             state_reg;
  logic [BAUD_W-1:0]       baud_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [UART_DATA_W-1:0]  shift_reg;
  logic [IDX_W-1:0]        ptr_reg;
  logic [IDX_W-1:0]        ptr_next;
  logic [IDX_W-1:0]        grant_id_reg;
  logic                    tx_reg;

  logic                    any_valid;
  logic [IDX_W-1:0]        winner;
  logic                    baud_last;
  logic                    offer;
  logic [UART_DATA_W-1:0]  req_bytes [NUM_REQ];

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // A reset cycle never offers a grant, even when the sequencer sits in IDLE.
  assign offer     = (state_reg == IDLE) && any_valid && !reset;
  assign baud_last = (baud_cnt_reg == BAUD_LAST);
  assign ptr_next  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
      assign req_ready[gi] = offer && (winner == IDX_W'(gi));
    end
  endgenerate

  // The line level is loaded together with each state/bit transition so the
  // start bit is on the pin the cycle after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      grant_id_reg <= '0;
      tx_reg       <= UART_IDLE_LEVEL;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          tx_reg       <= UART_IDLE_LEVEL;
          if (offer) begin
            shift_reg    <= req_bytes[winner];
            grant_id_reg <= winner;
            ptr_reg      <= ptr_next;
            state_reg    <= START;
            tx_reg       <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= DATA;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_reg <= STOP;
              tx_reg    <= UART_IDLE_LEVEL;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= shift_reg[bit_cnt_reg + 1'b1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
          tx_reg <= UART_IDLE_LEVEL;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_id_reg;
  assign UART_TX  = tx_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model checked every cycle,
// plus a line decoder for directed byte/grant-order checks.
module tb_uart_tx_scheduler;

  localparam int N   = 3;
  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           UART_TX;

  uart_tx_scheduler #(
    .NUM_REQ      (N),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .UART_TX   (UART_TX)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a 10-bit pattern {stop, data, start} played
  // out over FL cycles; idle between frames.
  int         m_left = 0;
  int         m_el = 0;
  int         m_ptr = 0;
  int         m_grant = 0;
  logic [9:0] m_frame = '1;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   rdy1_cnt = 0;
  logic line_q[$];
  int   grant_q[$];
  int   byte_q[$];

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = (m_left == 0 && !reset) ? pick() : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("tx", UART_TX, (m_left == 0) ? 1'b1 : m_frame[m_el / CPB]);
    check("busy", busy, m_left != 0);
    check("grant", grant_id, m_grant);
    check("ready", req_ready, exp_rdy);
    check("onehot", $countones(req_ready) <= 1, 1);
    line_q.push_back(UART_TX);
    if (busy === 1'b1) busy_cnt++;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1) begin
        grant_q.push_back(i);
        if (i == 1) rdy1_cnt++;
      end
    end
    @(posedge clk);
    if (reset) begin
      m_left = 0; m_el = 0; m_ptr = 0; m_grant = 0;
    end else if (m_left != 0) begin
      m_left--; m_el++;
    end else if (w >= 0) begin
      m_frame = {1'b1, req_data[8*w +: 8], 1'b0};
      m_left = FL; m_el = 0; m_grant = w; m_ptr = (w + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Recover bytes from the recorded line by mid-bit sampling after each start bit.
  task automatic decode_line();
    int i;
    logic [7:0] b;
    byte_q.delete();
    i = 0;
    while (i + FL <= line_q.size()) begin
      if (line_q[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + CPB*(k+1) + CPB/2];
        byte_q.push_back(int'(b));
        i += FL;
      end else begin
        i++;
      end
    end
    line_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run(2);

    // Single requester, 0x55
    reset = 1'b0;
    line_q.delete(); busy_cnt = 0;
    req_valid = 3'b001; req_data[7:0] = 8'h55;
    tick();
    req_valid = '0;
    run(FL + 5);
    decode_line();
    check("t1_nbytes", byte_q.size(), 1);
    check("t1_byte", byte_q[0], 32'h55);
    check("t1_busy_len", busy_cnt, FL);

    // Two held requesters over four frames
    reset = 1'b1; tick(); reset = 1'b0;
    line_q.delete(); grant_q.delete();
    req_valid = 3'b011; req_data = {8'h00, 8'h31, 8'h30};
    run(4 * (FL + 1));
    req_valid = '0;
    run(FL + 2);
    decode_line();
    check("t3_ngrants", grant_q.size(), 4);
    check("t3_nbytes", byte_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_grant", grant_q[k], k % 2);
      check("t3_byte", byte_q[k], (k % 2) ? 32'h31 : 32'h30);
    end

    // Reset during DATA bit 3, then simultaneous valids
    req_valid = 3'b001; req_data[7:0] = 8'h3C;
    tick();
    req_valid = '0;
    run(CPB + 3*CPB + 1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    check("t4_tx", UART_TX, 1);
    check("t4_busy", busy, 0);
    check("t4_grant", grant_id, 0);
    req_valid = 3'b011;
    tick();
    req_valid = '0;
    #1;
    check("t4_first_grant", grant_id, 0);
    run(FL + 2);
    line_q.delete();

    // Requester 1 pulses while busy and drops before the frame ends
    rdy1_cnt = 0;
    req_valid = 3'b001; req_data[7:0] = 8'h96;
    tick();
    req_valid = '0;
    run(10);
    req_valid = 3'b010;
    run(10);
    req_valid = '0;
    run(FL);
    decode_line();
    check("t5_rdy1", rdy1_cnt, 0);
    check("t5_nbytes", byte_q.size(), 1);
    check("t5_byte", byte_q[0], 32'h96);
    #1;
    check("t5_idle", busy, 0);

    // Data changes right after the handshake
    req_valid = 3'b001; req_data[7:0] = 8'hA5;
    tick();
    req_data[7:0] = 8'h00; req_valid = '0;
    run(FL + 2);
    decode_line();
    check("t6_byte", byte_q[0], 32'hA5);

    // Randomised traffic with occasional resets
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req_valid[i] = ~req_valid[i];
      req_data = 24'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    req_valid = '0;
    run(FL + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
